// File: rtl/bbcd_seq_conv_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
package bbcd_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [3:0] ADJ_THR = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;

  // ceil(n*log10(2)); 0.30103 never lands on an integer for n in 1..32
  function automatic int bbcd_ndig(input int n);
    int d;
    d = 0;
    for (int i = 1; i <= 12; i++)
      if ((i - 1) * 100000 < n * 30103) d = i;
    return d;
  endfunction
endpackage

// File: rtl/bbcd_seq_conv_if.sv
// Handshake/result bundle between the ALU-side requester and the converter.
interface bbcd_seq_conv_if #(parameter int N_BITS = 16);
  import bbcd_pkg::*;
  localparam int N_DIG = bbcd_ndig(N_BITS);

  logic                 start;
  logic                 abort;
  logic [N_BITS-1:0]    bin;
  logic                 busy;
  logic                 done;
  logic [4*N_DIG-1:0]   bcd;

  modport master (output start, abort, bin, input busy, done, bcd);
  modport slave  (input start, abort, bin, output busy, done, bcd);
endinterface

// File: rtl/bbcd_seq_conv_iter_cnt.sv
// Loadable down counter with registered zero flag; saturates at 0.
module bbcd_iter_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         z
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      z   <= 1'b1;
    end else if (ld) begin
      cnt <= ld_val;
      z   <= 1'b0;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
      z   <= (cnt == W'(1));
    end
  end
endmodule

// File: rtl/bbcd_seq_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done,
// abort and a result register held between conversions.
module bbcd_seq_conv
  import bbcd_pkg::*;
#(
  parameter int N_BITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  bbcd_seq_conv_if.slave  bus
);
  localparam int N_DIG = bbcd_ndig(N_BITS);
  localparam int CNT_W = $clog2(N_BITS + 1);
  localparam int SW    = 4 * N_DIG;

  logic [1:0]          state;
  logic                busy, done;
  logic [SW-1:0]       bcd_q;
  logic [SW-1:0]       scratch, scr_adj;
  logic [N_BITS-1:0]   shreg;
  logic [SW+N_BITS-1:0] cat_sh;
  logic [CNT_W-1:0]    cnt;
  logic                z;
  logic                accept, step, last;

  assign accept = (state == ST_IDLE) && bus.start && !bus.abort;
  assign step   = (state == ST_CONV) && !bus.abort && !z;
  assign last   = (cnt == CNT_W'(1));

  bbcd_iter_cnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (accept),
    .ld_val (CNT_W'(N_BITS)),
    .dec    (step),
    .cnt    (cnt),
    .z      (z)
  );

  // Per-digit correction before the shift; 4-bit wrap, no carry between digits
  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    logic [3:0] dig;
    assign dig = scratch[4*g +: 4];
    assign scr_adj[4*g +: 4] = (dig >= ADJ_THR) ? dig + ADJ_ADD : dig;
  end

  assign cat_sh = {scr_adj, shreg} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_q   <= '0;
      scratch <= '0;
      shreg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          shreg   <= bus.bin;
          scratch <= '0;
          busy    <= 1'b1;
          state   <= ST_CONV;
        end
        ST_CONV: if (bus.abort) begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end else if (!z) begin
          {scratch, shreg} <= cat_sh;
          if (last) begin
            bcd_q <= cat_sh[SW+N_BITS-1 -: SW];
            done  <= 1'b1;
            state <= ST_FIN;
          end
        end
        // Abort here lands in the same place; done has already pulsed
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.bcd  = bcd_q;
endmodule
